// File: rtl/channel_pkg.sv
// Shared types and constants for the channel reader: message meta record,
// fixed AXI read-burst encoding and the per-message output beat count.
package channel_pkg;

  localparam int BEATS_PER_MSG = 64;
  localparam int BURST_SHIFT   = 9;  // 16 beats x 32 B per burst

  localparam logic [1:0] BURST_INCR = 2'd1;
  localparam logic [2:0] SIZE_32B   = 3'd5;
  localparam logic [3:0] LEN_16     = 4'd15;

  typedef struct packed {
    logic [15:0] qpn;
    logic [23:0] msg_num;
    logic [20:0] pkg_num;
    logic [20:0] pkg_total;
  } meta_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_META,
    ST_READ
  } state_e;

  function automatic logic [32:0] burst_addr(input logic [20:0] msg_idx,
                                             input logic [31:0] k,
                                             input int          shift);
    logic [32:0] base;
    base = 33'(msg_idx) << shift;
    return base + (33'(k) << BURST_SHIFT);
  endfunction

endpackage

// File: rtl/channel_reader_if.sv
// Command, meta, AXI read and packed data-stream signals of the channel reader.
// master is the reader's view, slave the surrounding TX engine / memory view.
interface channel_reader_if;

  logic         send_cmd_valid;
  logic         send_cmd_ready;
  logic [15:0]  send_cmd_bits_qpn;
  logic [23:0]  send_cmd_bits_msg_num;
  logic [20:0]  send_cmd_bits_pkg_total;

  logic         send_meta_valid;
  logic         send_meta_ready;
  logic [15:0]  send_meta_bits_qpn;
  logic [23:0]  send_meta_bits_msg_num;
  logic [20:0]  send_meta_bits_pkg_num;
  logic [20:0]  send_meta_bits_pkg_total;

  logic         ar_valid;
  logic         ar_ready;
  logic [32:0]  ar_bits_addr;
  logic [1:0]   ar_bits_burst;
  logic [3:0]   ar_bits_cache;
  logic [5:0]   ar_bits_id;
  logic [3:0]   ar_bits_len;
  logic         ar_bits_lock;
  logic [2:0]   ar_bits_prot;
  logic [3:0]   ar_bits_qos;
  logic [3:0]   ar_bits_region;
  logic [2:0]   ar_bits_size;

  logic         r_valid;
  logic         r_ready;
  logic [255:0] r_bits_data;
  logic         r_bits_last;
  logic [1:0]   r_bits_resp;
  logic [5:0]   r_bits_id;

  logic         send_data_valid;
  logic         send_data_ready;
  logic         send_data_bits_last;
  logic [511:0] send_data_bits_data;
  logic [63:0]  send_data_bits_keep;

  modport master (
    input  send_cmd_valid, send_cmd_bits_qpn, send_cmd_bits_msg_num, send_cmd_bits_pkg_total,
    output send_cmd_ready,
    output send_meta_valid, send_meta_bits_qpn, send_meta_bits_msg_num,
           send_meta_bits_pkg_num, send_meta_bits_pkg_total,
    input  send_meta_ready,
    output ar_valid, ar_bits_addr, ar_bits_burst, ar_bits_cache, ar_bits_id, ar_bits_len,
           ar_bits_lock, ar_bits_prot, ar_bits_qos, ar_bits_region, ar_bits_size,
    input  ar_ready,
    input  r_valid, r_bits_data, r_bits_last, r_bits_resp, r_bits_id,
    output r_ready,
    output send_data_valid, send_data_bits_last, send_data_bits_data, send_data_bits_keep,
    input  send_data_ready
  );

  modport slave (
    output send_cmd_valid, send_cmd_bits_qpn, send_cmd_bits_msg_num, send_cmd_bits_pkg_total,
    input  send_cmd_ready,
    input  send_meta_valid, send_meta_bits_qpn, send_meta_bits_msg_num,
           send_meta_bits_pkg_num, send_meta_bits_pkg_total,
    output send_meta_ready,
    input  ar_valid, ar_bits_addr, ar_bits_burst, ar_bits_cache, ar_bits_id, ar_bits_len,
           ar_bits_lock, ar_bits_prot, ar_bits_qos, ar_bits_region, ar_bits_size,
    output ar_ready,
    output r_valid, r_bits_data, r_bits_last, r_bits_resp, r_bits_id,
    input  r_ready,
    input  send_data_valid, send_data_bits_last, send_data_bits_data, send_data_bits_keep,
    output send_data_ready
  );

endinterface

// File: rtl/channel_reader_axi_r_packer.sv
// 256->512 gearbox: pairs consecutive R beats into one output beat and flags
// the final beat of each message.
module axi_r_packer
  import channel_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         en_i,
  input  logic         r_valid_i,
  input  logic [255:0] r_data_i,
  output logic         r_ready_o,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic [511:0] out_data_o,
  output logic         out_last_o,
  output logic         msg_done_o
);

  localparam int BCW = $clog2(BEATS_PER_MSG);

  logic           half_q;
  logic           out_valid_q;
  logic           out_last_q;
  logic [BCW-1:0] beat_cnt_q;
  logic [255:0]   lo_q;
  logic [511:0]   out_data_q;
  logic           r_fire;
  logic           out_fire;

  // The upper half may only land when the output register is free or draining.
  assign r_ready_o  = en_i && (!half_q || !out_valid_q || out_ready_i);
  assign r_fire     = r_valid_i && r_ready_o;
  assign out_fire   = out_valid_q && out_ready_i;
  assign msg_done_o = out_fire && out_last_q;

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      half_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      if (out_fire) out_valid_q <= 1'b0;
      if (r_fire) begin
        half_q <= !half_q;
        if (half_q) begin
          out_valid_q <= 1'b1;
          out_last_q  <= (int'(beat_cnt_q) == BEATS_PER_MSG - 1);
          beat_cnt_q  <= beat_cnt_q + BCW'(1);
        end
      end
    end
  end

  // NOTE: pure datapath registers carry no reset; out_valid_q/half_q qualify them.
  always_ff @(posedge clock) begin
    if (r_fire && !half_q) lo_q <= r_data_i;
    if (r_fire && half_q)  out_data_q <= {r_data_i, lo_q};
  end

endmodule

// File: rtl/channel_reader.sv
// Channel reader top: command -> meta -> AXI burst reads packed to 512-bit data.
// Optional sticky RRESP error flag enabled by CHANNEL_READER_RRESP_CHECK_EN.
module channel_reader
  import channel_pkg::*;
#(
  parameter int BURSTS_PER_MSG  = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_SHIFT      = 12
) (
  input  logic             clock,
  input  logic             reset,
  channel_reader_if.master bus,
  output logic             io_rd_err
);

  localparam int ARW = $clog2(BURSTS_PER_MSG + 1);
  localparam int OSW = $clog2(MAX_OUTSTANDING + 1);

  state_e         state_q;
  logic           cmd_ready_q;
  logic           meta_valid_q;
  meta_t          meta_q;
  logic           ar_valid_q;
  logic [32:0]    ar_addr_q;
  logic [ARW-1:0] ar_cnt_q, ar_cnt_d;
  logic [OSW-1:0] outst_q, outst_d;
  logic           pk_r_ready;
  logic           msg_done;
  logic           ar_fire;
  logic           r_fire;
  logic           r_last_fire;

  assign ar_fire     = ar_valid_q && bus.ar_ready;
  assign r_fire      = bus.r_valid && pk_r_ready;
  assign r_last_fire = r_fire && bus.r_bits_last;

  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    ar_cnt_d = ar_cnt_q;
    outst_d  = outst_q;
    if (ar_fire) ar_cnt_d = ar_cnt_q + ARW'(1);
    if (ar_fire && !r_last_fire)                          outst_d = outst_q + OSW'(1);
    else if (!ar_fire && r_last_fire && outst_q != '0)    outst_d = outst_q - OSW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b0;
      meta_valid_q <= 1'b0;
      meta_q       <= '0;
      ar_valid_q   <= 1'b0;
      ar_addr_q    <= '0;
      ar_cnt_q     <= '0;
      outst_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.send_cmd_valid && cmd_ready_q) begin
            cmd_ready_q  <= 1'b0;
            meta_valid_q <= 1'b1;
            meta_q       <= '{qpn:       bus.send_cmd_bits_qpn,
                              msg_num:   bus.send_cmd_bits_msg_num,
                              pkg_num:   '0,
                              pkg_total: bus.send_cmd_bits_pkg_total};
            state_q      <= ST_META;
          end
        end
        ST_META: begin
          if (bus.send_meta_ready) begin
            meta_valid_q <= 1'b0;
            ar_valid_q   <= 1'b1;
            ar_addr_q    <= burst_addr(meta_q.msg_num[20:0], 32'd0, ADDR_SHIFT);
            state_q      <= ST_READ;
          end
        end
        ST_READ: begin
          // Next AR is decided from post-edge counts so a held request keeps its address.
          ar_cnt_q   <= ar_cnt_d;
          outst_q    <= outst_d;
          ar_valid_q <= (int'(ar_cnt_d) < BURSTS_PER_MSG) && (int'(outst_d) < MAX_OUTSTANDING);
          ar_addr_q  <= burst_addr(meta_q.msg_num[20:0], 32'(ar_cnt_d), ADDR_SHIFT);
          if (msg_done) begin
            ar_cnt_q    <= '0;
            ar_valid_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  axi_r_packer u_packer (
    .clock       (clock),
    .reset       (reset),
    .en_i        (state_q == ST_READ),
    .r_valid_i   (bus.r_valid),
    .r_data_i    (bus.r_bits_data),
    .r_ready_o   (pk_r_ready),
    .out_ready_i (bus.send_data_ready),
    .out_valid_o (bus.send_data_valid),
    .out_data_o  (bus.send_data_bits_data),
    .out_last_o  (bus.send_data_bits_last),
    .msg_done_o  (msg_done)
  );

  assign bus.send_cmd_ready           = cmd_ready_q;
  assign bus.send_meta_valid          = meta_valid_q;
  assign bus.send_meta_bits_qpn       = meta_q.qpn;
  assign bus.send_meta_bits_msg_num   = meta_q.msg_num;
  assign bus.send_meta_bits_pkg_num   = meta_q.pkg_num;
  assign bus.send_meta_bits_pkg_total = meta_q.pkg_total;

  assign bus.ar_valid       = ar_valid_q;
  assign bus.ar_bits_addr   = ar_addr_q;
  assign bus.ar_bits_burst  = BURST_INCR;
  assign bus.ar_bits_size   = SIZE_32B;
  assign bus.ar_bits_len    = LEN_16;
  assign bus.ar_bits_cache  = 4'd0;
  assign bus.ar_bits_id     = 6'd0;
  assign bus.ar_bits_lock   = 1'b0;
  assign bus.ar_bits_prot   = 3'd0;
  assign bus.ar_bits_qos    = 4'd0;
  assign bus.ar_bits_region = 4'd0;

  assign bus.r_ready             = pk_r_ready;
  assign bus.send_data_bits_keep = '1;

`ifdef CHANNEL_READER_RRESP_CHECK_EN
  logic rd_err_q;
  logic unused_r_id;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                               rd_err_q <= 1'b0;
    else if (r_fire && bus.r_bits_resp != 2'd0) rd_err_q <= 1'b1;
  end

  assign io_rd_err   = rd_err_q;
  assign unused_r_id = ^bus.r_bits_id;
`else
  logic unused_r_bits;

  assign io_rd_err     = 1'b0;
  assign unused_r_bits = ^{bus.r_bits_id, bus.r_bits_resp};
`endif

endmodule

// File: tb/tb_channel_reader.sv
// Self-checking bench for channel_reader: randomized AXI/stream handshakes
// scored against a queue-based model of commands, bursts and packed beats.
module tb_channel_reader;

`ifdef CHANNEL_READER_RRESP_CHECK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_err;

  channel_reader_if bus ();

  channel_reader dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus),
    .io_rd_err (rd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stimulus knobs
  bit ar_en = 1'b1, ar_rand = 1'b0, r_en = 1'b1, r_rand = 1'b0, meta_rand = 1'b0;
  bit r_count_data = 1'b0;
  int d_mode = 0;
  int resp_beat = -1;

  // reference model state
  int            cyc = 0;
  bit            busy = 1'b0;
  logic [23:0]   cur_msg = '0;
  logic [81:0]   exp_meta_q[$];
  logic [511:0]  exp_q[$];
  int            meta_due = 0;
  int            cmd_fires = 0, ar_k = 0, ar_total = 0, outst = 0, bursts_pending = 0;
  int            msgs_done = 0, out_cnt = 0, total_out = 0;
  logic [32:0]   first_ar_addr = '0;
  logic [511:0]  first_out = '0;

  always @(posedge clk) cyc++;

  // command acceptance monitor
  initial forever begin
    @(negedge clk); #2;
    if (rst) begin
      busy = 1'b0;
      exp_meta_q.delete();
    end else if (bus.send_cmd_valid && bus.send_cmd_ready) begin
      check("cmd_while_busy", busy, 1'b0);
      busy = 1'b1;
      cmd_fires++;
      cur_msg = bus.send_cmd_bits_msg_num;
      ar_k = 0;
      exp_meta_q.push_back({bus.send_cmd_bits_qpn, bus.send_cmd_bits_msg_num, 21'd0,
                            bus.send_cmd_bits_pkg_total});
      meta_due = cyc + 1;
    end
  end

  // meta sink
  initial begin
    bit meta_prev, meta_hold;
    logic [81:0] meta_held, meta_obs;
    meta_prev = 0; meta_hold = 0; meta_held = '0;
    bus.send_meta_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.send_meta_ready = !rst && (!meta_rand || $urandom_range(0, 1) == 1);
      #2;
      if (rst) begin
        meta_prev = 0; meta_hold = 0;
      end else begin
        meta_obs = {bus.send_meta_bits_qpn, bus.send_meta_bits_msg_num,
                    bus.send_meta_bits_pkg_num, bus.send_meta_bits_pkg_total};
        if (bus.send_meta_valid && !meta_prev) check("meta_latency", cyc, meta_due);
        if (meta_hold) check("meta_stable", {bus.send_meta_valid, meta_obs}, {1'b1, meta_held});
        if (bus.send_meta_valid && bus.send_meta_ready) begin
          check("meta_queue", exp_meta_q.size() > 0, 1'b1);
          if (exp_meta_q.size() > 0) check("meta_fields", meta_obs, exp_meta_q.pop_front());
        end
        meta_prev = bus.send_meta_valid;
        meta_hold = bus.send_meta_valid && !bus.send_meta_ready;
        meta_held = meta_obs;
      end
    end
  end

  // AR slave and address model
  initial begin
    bit ar_hold;
    logic [32:0] ar_prev, ar_exp;
    ar_hold = 0; ar_prev = '0;
    bus.ar_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_k = 0; outst = 0; ar_hold = 0;
        bus.ar_ready = 1'b0;
      end else begin
        bus.ar_ready = ar_en && (!ar_rand || $urandom_range(0, 1) == 1);
      end
      #2;
      if (!rst) begin
        if (ar_hold) begin
          check("ar_valid_held", bus.ar_valid, 1'b1);
          check("ar_addr_stable", bus.ar_bits_addr, ar_prev);
        end
        ar_hold = bus.ar_valid && !bus.ar_ready;
        ar_prev = bus.ar_bits_addr;
        if (bus.ar_valid && bus.ar_ready) begin
          ar_exp = (33'(cur_msg[20:0]) << 12) + 33'(ar_k) * 33'd512;
          check("ar_addr", bus.ar_bits_addr, ar_exp);
          check("ar_fields", {bus.ar_bits_burst, bus.ar_bits_size, bus.ar_bits_len,
                              bus.ar_bits_cache, bus.ar_bits_id, bus.ar_bits_lock,
                              bus.ar_bits_prot, bus.ar_bits_qos, bus.ar_bits_region},
                {2'd1, 3'd5, 4'd15, 22'd0});
          if (ar_total == 0) first_ar_addr = bus.ar_bits_addr;
          ar_k++; ar_total++; outst++; bursts_pending++;
          check("ar_outstanding_limit", outst <= 4, 1'b1);
          check("ar_per_msg_limit", ar_k <= 8, 1'b1);
        end
      end
    end
  end

  // R master: returns 16-beat bursts for accepted ARs, builds expected pairs
  initial begin
    bit r_fired, have_lo;
    int rbeat, msg_rbeat;
    logic [255:0] lo, d;
    r_fired = 0; have_lo = 0; rbeat = 0; msg_rbeat = 0; lo = '0;
    bus.r_valid = 1'b0; bus.r_bits_data = '0; bus.r_bits_last = 1'b0;
    bus.r_bits_resp = 2'd0; bus.r_bits_id = 6'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.r_valid = 1'b0;
        r_fired = 0; have_lo = 0; rbeat = 0; msg_rbeat = 0; bursts_pending = 0;
        exp_q.delete();
      end else begin
        if (r_fired) begin
          bus.r_valid = 1'b0;
          r_fired = 0;
        end
        if (!bus.r_valid && r_en && bursts_pending > 0 && (!r_rand || $urandom_range(0, 3) != 0)) begin
          if (r_count_data) d = 256'(msg_rbeat);
          else for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
          bus.r_valid     = 1'b1;
          bus.r_bits_data = d;
          bus.r_bits_last = (rbeat == 15);
          bus.r_bits_resp = (msg_rbeat == resp_beat) ? 2'd2 : 2'd0;
        end
      end
      #2;
      if (!rst && bus.r_valid && bus.r_ready) begin
        r_fired = 1;
        if (have_lo) begin
          exp_q.push_back({bus.r_bits_data, lo});
          have_lo = 0;
        end else begin
          lo = bus.r_bits_data;
          have_lo = 1;
        end
        msg_rbeat = (msg_rbeat + 1) % 128;
        if (bus.r_bits_last) begin
          bursts_pending--; outst--; rbeat = 0;
        end else begin
          rbeat++;
        end
      end
    end
  end

  // data sink and output scoreboard
  initial begin
    bit d_hold;
    logic [511:0] d_prev, ed;
    d_hold = 0; d_prev = '0;
    bus.send_data_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.send_data_ready = 1'b0;
        out_cnt = 0; d_hold = 0;
      end else begin
        case (d_mode)
          0:       bus.send_data_ready = 1'b1;
          1:       bus.send_data_ready = !bus.send_data_ready;
          default: bus.send_data_ready = ($urandom_range(0, 2) != 0);
        endcase
      end
      #2;
      if (!rst) begin
        if (d_hold) begin
          check("data_valid_held", bus.send_data_valid, 1'b1);
          check("data_stable", bus.send_data_bits_data, d_prev);
        end
        d_hold = bus.send_data_valid && !bus.send_data_ready;
        d_prev = bus.send_data_bits_data;
        if (bus.send_data_valid && bus.send_data_ready) begin
          check("data_queue", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            ed = exp_q.pop_front();
            check("data_value", bus.send_data_bits_data, ed);
          end
          check("data_last", bus.send_data_bits_last, out_cnt == 63);
          check("data_keep", bus.send_data_bits_keep, {64{1'b1}});
          if (total_out == 0) first_out = bus.send_data_bits_data;
          out_cnt++; total_out++;
          if (out_cnt == 64) begin
            out_cnt = 0; msgs_done++; busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic send_cmd(input logic [15:0] q, input logic [23:0] m, input logic [20:0] p);
    int start;
    bit ok;
    start = cmd_fires;
    ok = 0;
    @(negedge clk);
    bus.send_cmd_valid          = 1'b1;
    bus.send_cmd_bits_qpn       = q;
    bus.send_cmd_bits_msg_num   = m;
    bus.send_cmd_bits_pkg_total = p;
    for (int i = 0; i < 6000; i++) begin
      #3;
      if (cmd_fires != start) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("cmd_accept_timeout", ok, 1'b1);
    @(posedge clk); #1;
    bus.send_cmd_valid = 1'b0;
  endtask

  task automatic wait_msgs(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #3;
      if (msgs_done >= target) break;
    end
    check("msg_done_timeout", msgs_done >= target, 1'b1);
  endtask

  initial begin
    int target;
    bus.send_cmd_valid = 1'b0;
    bus.send_cmd_bits_qpn = '0;
    bus.send_cmd_bits_msg_num = '0;
    bus.send_cmd_bits_pkg_total = '0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", bus.send_cmd_ready, 1'b0);
    check("rst_meta_valid", bus.send_meta_valid, 1'b0);
    check("rst_ar_valid", bus.ar_valid, 1'b0);
    check("rst_r_ready", bus.r_ready, 1'b0);
    check("rst_data_valid", bus.send_data_valid, 1'b0);
    check("rst_rd_err", rd_err, 1'b0);
    rst = 1'b0;
    @(negedge clk); #3;
    check("idle_cmd_ready", bus.send_cmd_ready, 1'b1);

    // basic message with counting R data
    r_count_data = 1'b1;
    send_cmd(16'd5, 24'd3, 21'd1);
    wait_msgs(1, 2000);
    check("basic_first_ar", first_ar_addr, 33'h3000);
    check("basic_ar_total", ar_total, 8);
    check("basic_first_beat", first_out, {256'd1, 256'd0});
    check("basic_beats", total_out, 64);
    r_count_data = 1'b0;

    // back-to-back commands
    send_cmd(16'd1, 24'd1, 21'd7);
    send_cmd(16'd2, 24'd2, 21'd9);
    wait_msgs(3, 3000);
    check("b2b_ar_total", ar_total, 24);

    // outstanding limit with R withheld
    r_en = 1'b0;
    send_cmd(16'd3, 24'd4, 21'd2);
    repeat (30) @(negedge clk);
    #3;
    check("outst_ar_count", ar_k, 4);
    check("outst_ar_valid_low", bus.ar_valid, 1'b0);
    r_en = 1'b1;
    wait_msgs(4, 3000);

    // backpressure and random handshakes
    d_mode = 1; ar_rand = 1'b1; r_rand = 1'b1; meta_rand = 1'b1;
    send_cmd(16'($urandom()), 24'($urandom()), 21'($urandom()));
    wait_msgs(5, 4000);
    d_mode = 2;
    send_cmd(16'($urandom()), 24'($urandom()), 21'($urandom()));
    wait_msgs(6, 4000);
    d_mode = 0; ar_rand = 1'b0; r_rand = 1'b0; meta_rand = 1'b0;

    // read error response
    check("rd_err_before", rd_err, 1'b0);
    resp_beat = 5;
    send_cmd(16'd7, 24'd11, 21'd4);
    wait_msgs(7, 2000);
    resp_beat = -1;
    check("rd_err_set", rd_err, EXP_ERR);
    send_cmd(16'd8, 24'd12, 21'd4);
    wait_msgs(8, 2000);
    check("rd_err_sticky", rd_err, EXP_ERR);

    // reset in the middle of a message
    send_cmd(16'd9, 24'h1F_FFFF, 21'd5);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #3;
      if (out_cnt >= 20) break;
    end
    check("midrst_reached", out_cnt >= 20, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_meta_valid", bus.send_meta_valid, 1'b0);
    check("midrst_ar_valid", bus.ar_valid, 1'b0);
    check("midrst_data_valid", bus.send_data_valid, 1'b0);
    check("midrst_r_ready", bus.r_ready, 1'b0);
    check("midrst_cmd_ready", bus.send_cmd_ready, 1'b0);
    check("midrst_rd_err", rd_err, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk); #3;
    check("midrst_cmd_ready_back", bus.send_cmd_ready, 1'b1);
    target = msgs_done + 1;
    send_cmd(16'd10, 24'd6, 21'd3);
    wait_msgs(target, 2000);
    check("midrst_restart_out_cnt", out_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
